// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect controller: computes the EX target, requests a fetch
// redirect, then flushes the front-end for a fixed number of cycles.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter bit SUPPORT_C    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_EX,
  input  logic        jump_EX,
  input  logic        jalr_EX,
  input  logic        branch_EX,
  input  logic        branch_taken_EX,
  input  logic [31:0] bt_a_operand_i,
  input  logic [31:0] bt_b_operand_i,
  input  logic        kill_i,
  input  logic        redirect_ready_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_target_o,
  output logic        flush_ID_o,
  output logic        stall_EX_o,
  output logic        misaligned_exc_o,
  output logic [31:0] exc_tval_o,
  output logic [15:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state;
  logic [2:0]  fcnt;
  logic [15:0] cnt;
  logic [31:0] sum;
  logic [31:0] target;
  logic        take;
  logic        misaligned;

  assign take = instr_valid_EX
              & (jump_EX | (branch_EX & branch_taken_EX));

  assign sum = bt_a_operand_i + bt_b_operand_i;

  // JALR clears bit 0 of the computed address
  assign target = (jump_EX & jalr_EX)
                ? {sum[31:1], 1'b0}
                : sum;

  assign misaligned = SUPPORT_C
                    ? target[0]
                    : (target[1:0] != 2'b00);

  assign redirect_cnt_o = cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      fcnt              <= 3'd0;
      cnt               <= 16'd0;
      redirect_valid_o  <= 1'b0;
      redirect_target_o <= 32'd0;
      flush_ID_o        <= 1'b0;
      stall_EX_o        <= 1'b0;
      misaligned_exc_o  <= 1'b0;
      exc_tval_o        <= 32'd0;
    end else begin
      misaligned_exc_o <= 1'b0;
      if (kill_i) begin
        state            <= IDLE;
        fcnt             <= 3'd0;
        redirect_valid_o <= 1'b0;
        flush_ID_o       <= 1'b0;
        stall_EX_o       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (take) begin
              if (misaligned) begin
                misaligned_exc_o <= 1'b1;
                exc_tval_o       <= target;
              end else begin
                state             <= REDIRECT;
                redirect_target_o <= target;
                redirect_valid_o  <= 1'b1;
                stall_EX_o        <= 1'b1;
              end
            end
          end
          REDIRECT: begin
            if (redirect_valid_o && redirect_ready_i) begin
              state            <= FLUSH;
              fcnt             <= FLUSH_LOAD;
              redirect_valid_o <= 1'b0;
              flush_ID_o       <= 1'b1;
              if (cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
            end
          end
          FLUSH: begin
            if (fcnt == 3'd1) begin
              state      <= IDLE;
              fcnt       <= 3'd0;
              flush_ID_o <= 1'b0;
              stall_EX_o <= 1'b0;
            end else begin
              fcnt <= fcnt - 3'd1;
            end
          end
          default: begin
            state            <= IDLE;
            fcnt             <= 3'd0;
            redirect_valid_o <= 1'b0;
            flush_ID_o       <= 1'b0;
            stall_EX_o       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, corner
// sequences and random traffic against a behavioural model.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, jump, jalr, branch, taken;
  logic [31:0] a, b;
  logic        kill, rdy;

  logic        val0, fl0, st0, exc0;
  logic [31:0] tgt0, tval0;
  logic [15:0] cnt0;
  logic        val1, fl1, st1, exc1;
  logic [31:0] tgt1, tval1;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .SUPPORT_C(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_EX(valid), .jump_EX(jump), .jalr_EX(jalr),
    .branch_EX(branch), .branch_taken_EX(taken),
    .bt_a_operand_i(a), .bt_b_operand_i(b),
    .kill_i(kill), .redirect_ready_i(rdy),
    .redirect_valid_o(val0), .redirect_target_o(tgt0),
    .flush_ID_o(fl0), .stall_EX_o(st0),
    .misaligned_exc_o(exc0), .exc_tval_o(tval0),
    .redirect_cnt_o(cnt0)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(3), .SUPPORT_C(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_EX(valid), .jump_EX(jump), .jalr_EX(jalr),
    .branch_EX(branch), .branch_taken_EX(taken),
    .bt_a_operand_i(a), .bt_b_operand_i(b),
    .kill_i(kill), .redirect_ready_i(rdy),
    .redirect_valid_o(val1), .redirect_target_o(tgt1),
    .flush_ID_o(fl1), .stall_EX_o(st1),
    .misaligned_exc_o(exc1), .exc_tval_o(tval1),
    .redirect_cnt_o(cnt1)
  );

  // {valid, jump, jalr, branch, taken}
  localparam logic [4:0] NOP  = 5'b00000;
  localparam logic [4:0] BR   = 5'b10011;
  localparam logic [4:0] BRN  = 5'b10010;
  localparam logic [4:0] JAL  = 5'b11000;
  localparam logic [4:0] JALR = 5'b11100;

  int n_chk = 0;
  int n_pass = 0;

  // Model: pending redirect flag plus remaining flush cycles
  int unsigned fc[2] = '{2, 3};
  int unsigned al[2] = '{2, 4};
  bit          m_pend[2];
  int          m_fl[2];
  logic [31:0] m_tgt[2];
  logic [31:0] m_tval[2];
  bit          m_exc[2];
  int          m_cnt[2];

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] a, b;
    bit          kill, rdy;
    bit          ev, efl, est, eexc;
    logic [31:0] etgt, etval;
    int          ecnt;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(logic [4:0] c, logic [31:0] va,
      logic [31:0] vb, bit k, bit r, bit ev, bit efl, bit est,
      bit eexc, logic [31:0] etgt, logic [31:0] etval, int ecnt);
    vec_t v;
    v.ctl = c; v.a = va; v.b = vb; v.kill = k; v.rdy = r;
    v.ev = ev; v.efl = efl; v.est = est; v.eexc = eexc;
    v.etgt = etgt; v.etval = etval; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(string name, logic [83:0] act,
                       logic [83:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, act, exp);
  endtask

  function automatic logic [83:0] obs(int i);
    if (i == 0) return {val0, fl0, st0, exc0, tgt0, tval0, cnt0};
    return {val1, fl1, st1, exc1, tgt1, tval1, cnt1};
  endfunction

  function automatic logic [83:0] model_out(int i);
    return {m_pend[i], m_fl[i] > 0, m_pend[i] || m_fl[i] > 0,
            m_exc[i], m_tgt[i], m_tval[i], 16'(m_cnt[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_fl[i] = 0; m_tgt[i] = '0;
      m_tval[i] = '0; m_exc[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge(input int i);
    logic [31:0] t;
    bit tk;
    tk = valid && (jump || (branch && taken));
    t = a + b;
    if (jump && jalr) t = t & ~32'd1;
    m_exc[i] = 0;
    if (kill) begin
      m_pend[i] = 0;
      m_fl[i] = 0;
    end else if (m_pend[i]) begin
      if (rdy) begin
        m_pend[i] = 0;
        m_fl[i] = int'(fc[i]);
        if (m_cnt[i] < 65535) m_cnt[i]++;
      end
    end else if (m_fl[i] > 0) begin
      m_fl[i]--;
    end else if (tk) begin
      if (t % al[i] != 0) begin
        m_exc[i] = 1;
        m_tval[i] = t;
      end else begin
        m_pend[i] = 1;
        m_tgt[i] = t;
      end
    end
  endtask

  task automatic drive(logic [4:0] c, logic [31:0] va,
                       logic [31:0] vb, bit k, bit r);
    {valid, jump, jalr, branch, taken} = c;
    a = va; b = vb; kill = k; rdy = r;
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    @(negedge clk);
    check("model0", obs(0), model_out(0));
    check("model1", obs(1), model_out(1));
  endtask

  initial begin
    rst = 1'b1;
    drive(NOP, 0, 0, 0, 0);
    model_reset();

    tbl[0]  = mk(BR,   32'h1000, 32'h20, 0, 1, 1, 0, 1, 0, 32'h1020, 0, 0);
    tbl[1]  = mk(NOP,  0, 0, 0, 1, 0, 1, 1, 0, 32'h1020, 0, 1);
    tbl[2]  = mk(NOP,  0, 0, 0, 1, 0, 1, 1, 0, 32'h1020, 0, 1);
    tbl[3]  = mk(NOP,  0, 0, 0, 1, 0, 0, 0, 0, 32'h1020, 0, 1);
    tbl[4]  = mk(JALR, 32'h2003, 0, 0, 0, 1, 0, 1, 0, 32'h2002, 0, 1);
    tbl[5]  = mk(NOP,  0, 0, 0, 0, 1, 0, 1, 0, 32'h2002, 0, 1);
    tbl[6]  = mk(NOP,  0, 0, 0, 0, 1, 0, 1, 0, 32'h2002, 0, 1);
    tbl[7]  = mk(NOP,  0, 0, 0, 1, 0, 1, 1, 0, 32'h2002, 0, 2);
    tbl[8]  = mk(NOP,  0, 0, 0, 0, 0, 1, 1, 0, 32'h2002, 0, 2);
    tbl[9]  = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 32'h2002, 0, 2);
    tbl[10] = mk(BR,   32'h400, 32'h10, 0, 0, 1, 0, 1, 0, 32'h410, 0, 2);
    tbl[11] = mk(NOP,  0, 0, 1, 1, 0, 0, 0, 0, 32'h410, 0, 2);
    tbl[12] = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 32'h410, 0, 2);
    tbl[13] = mk(JAL,  32'hFFFF_FFF0, 32'h20, 0, 0, 1, 0, 1, 0, 32'h10, 0, 2);
    tbl[14] = mk(NOP,  0, 0, 0, 1, 0, 1, 1, 0, 32'h10, 0, 3);
    tbl[15] = mk(NOP,  0, 0, 0, 1, 0, 1, 1, 0, 32'h10, 0, 3);
    tbl[16] = mk(NOP,  0, 0, 0, 1, 0, 0, 0, 0, 32'h10, 0, 3);
    tbl[17] = mk(BR,   32'h101, 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h101, 3);
    tbl[18] = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h101, 3);
    tbl[19] = mk(BR,   32'h777, 1, 1, 0, 0, 0, 0, 0, 32'h10, 32'h101, 3);
    tbl[20] = mk(BRN,  32'h200, 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h101, 3);
    tbl[21] = mk(BR,   32'h3000, 4, 0, 0, 1, 0, 1, 0, 32'h3004, 32'h101, 3);
    tbl[22] = mk(BR,   32'h5000, 0, 0, 0, 1, 0, 1, 0, 32'h3004, 32'h101, 3);
    tbl[23] = mk(BR,   32'h6000, 0, 0, 1, 0, 1, 1, 0, 32'h3004, 32'h101, 4);
    tbl[24] = mk(JAL,  32'h7000, 0, 0, 0, 0, 1, 1, 0, 32'h3004, 32'h101, 4);
    tbl[25] = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 32'h101, 4);
    tbl[26] = mk(JAL,  32'h80, 0, 0, 0, 1, 0, 1, 0, 32'h80, 32'h101, 4);
    tbl[27] = mk(NOP,  0, 0, 0, 1, 0, 1, 1, 0, 32'h80, 32'h101, 5);
    tbl[28] = mk(NOP,  0, 0, 1, 0, 0, 0, 0, 0, 32'h80, 32'h101, 5);
    tbl[29] = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 32'h101, 5);

    repeat (2) @(negedge clk);
    check("reset0", obs(0), 84'd0);
    check("reset1", obs(1), 84'd0);
    rst = 1'b0;

    for (int k = 0; k < 30; k++) begin
      drive(tbl[k].ctl, tbl[k].a, tbl[k].b, tbl[k].kill, tbl[k].rdy);
      step();
      check($sformatf("vec%0d", k), obs(0),
            {tbl[k].ev, tbl[k].efl, tbl[k].est, tbl[k].eexc,
             tbl[k].etgt, tbl[k].etval, 16'(tbl[k].ecnt)});
    end

    // 4-byte alignment: JAL to 0x102 faults on the non-C instance
    drive(NOP, 0, 0, 1, 0);
    step();
    drive(JAL, 32'h100, 32'h2, 0, 0);
    step();
    check("noc_exc", {exc1, val1, tval1}, {1'b1, 1'b0, 32'h102});
    drive(NOP, 0, 0, 0, 0);
    step();
    check("noc_pulse", {exc1, val1}, 2'b00);

    // Reset in first flush cycle, then a clean redirect
    drive(NOP, 0, 0, 1, 0);
    step();
    drive(BR, 32'h1000, 32'h20, 0, 0);
    step();
    drive(NOP, 0, 0, 0, 1);
    step();
    check("flush1", fl0, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async0", obs(0), 84'd0);
    check("rst_async1", obs(1), 84'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(BR, 32'h1000, 32'h20, 0, 1);
    step();
    check("post_rst_req", {val0, tgt0, cnt0},
          {1'b1, 32'h1020, 16'd0});
    drive(NOP, 0, 0, 0, 1);
    step();
    check("post_rst_fl1", {val0, fl0, cnt0}, {1'b0, 1'b1, 16'd1});
    step();
    check("post_rst_fl2", fl0, 1'b1);
    step();
    check("post_rst_idle", {fl0, st0}, 2'b00);
    repeat (2) step();

    // Saturation from a preloaded count
    force u0.cnt = 16'hFFFF;
    m_cnt[0] = 65535;
    drive(BR, 32'h40, 0, 0, 0);
    step();
    drive(NOP, 0, 0, 0, 1);
    step();
    release u0.cnt;
    #1;
    check("saturate", {fl0, cnt0}, {1'b1, 16'hFFFF});
    repeat (3) step();

    for (int k = 0; k < 600; k++) begin
      logic [4:0] c;
      c = 5'($urandom);
      c[4] = ($urandom_range(0, 3) != 0);
      drive(c, $urandom, 32'($urandom_range(0, 15)),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) != 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of cycles flush_ID_o is held after a redirect is accepted (legal range 1..7).
REQ-002 SHALL have parameter SUPPORT_C, default 1: 1 = compressed ISA present (2-byte target alignment); 0 = 4-byte alignment required.
REQ-003 SHALL use one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-004 clk_i  in  1  core clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 instr_valid_EX  in  1  EX holds a valid instruction this cycle.
REQ-007 jump_EX  in  1  EX instruction is JAL or JALR (unconditional).
REQ-008 jalr_EX  in  1  EX instruction is JALR (qualifies jump_EX).
REQ-009 branch_EX  in  1  EX instruction is a conditional branch.
REQ-010 branch_taken_EX  in  1  branch comparison result from the EX ALU.
REQ-011 bt_a_operand_i  in  32  branch-target operand A: PC or rs1 data.
REQ-012 bt_b_operand_i  in  32  branch-target operand B: immediate or PC increment.
REQ-013 kill_i  in  1  writeback exception/interrupt; cancels any pending redirect.
REQ-014 redirect_ready_i  in  1  IF accepts the redirect this cycle.
REQ-015 redirect_valid_o  out  1  redirect request to IF.
REQ-016 redirect_target_o  out  32  new fetch address; stable while redirect_valid_o=1.
REQ-017 flush_ID_o  out  1  invalidate the IF/ID and ID/EX pipeline registers.
REQ-018 stall_EX_o  out  1  hold the EX stage.
REQ-019 misaligned_exc_o  out  1  one-cycle pulse: instruction-address-misaligned.
REQ-020 exc_tval_o  out  32  faulting target; valid while misaligned_exc_o=1.
REQ-021 redirect_cnt_o  out  16  saturating count of accepted redirects.

Function
REQ-022 Request condition: take = instr_valid_EX & (jump_EX | (branch_EX & branch_taken_EX)), sampled in IDLE only.
REQ-023 Target sum: sum = bt_a_operand_i + bt_b_operand_i, modulo 2^32; carry out is discarded.
REQ-024 JALR target: target = sum with bit 0 forced to 0; all other instructions use target = sum unmodified.
REQ-025 Misalignment: SUPPORT_C=1 -> target[0]=1 is misaligned; SUPPORT_C=0 -> target[1:0]!=0 is misaligned.
REQ-026 FSM states SHALL be IDLE, REDIRECT and FLUSH.
REQ-027 IDLE, take, aligned, no kill_i:
- register target into redirect_target_o
- next state REDIRECT
- redirect_valid_o rises the following cycle (1-cycle latency)
REQ-028 IDLE, take, misaligned, no kill_i:
- misaligned_exc_o=1 next cycle, exc_tval_o=target
- no redirect issued; state stays IDLE
REQ-029 REDIRECT:
- redirect_valid_o=1 and stall_EX_o=1
- redirect_target_o held constant until the handshake
REQ-030 Handshake: redirect_valid_o & redirect_ready_i in a cycle -> next state FLUSH, flush counter loaded with FLUSH_CYCLES, redirect_cnt_o incremented.
REQ-031 redirect_cnt_o SHALL saturate at 16'hFFFF.
REQ-032 FLUSH:
- flush_ID_o=1 and stall_EX_o=1
- counter decrements each cycle
- return to IDLE on the cycle the counter reaches 1
- flush_ID_o therefore asserts for exactly FLUSH_CYCLES cycles
REQ-033 kill_i=1 in any state:
- next state IDLE; redirect_valid_o and flush_ID_o drop the next cycle
- no count increment, no exception pulse
- kill_i has priority over a same-cycle handshake and over a same-cycle take
REQ-034 In REDIRECT and FLUSH, EX inputs SHALL be ignored; a new take is not sampled until IDLE.
REQ-035 Output decode: stall_EX_o=0 in IDLE; flush_ID_o=0 outside FLUSH; redirect_valid_o=0 outside REDIRECT.

Reset
REQ-036 On rst_i assertion, asynchronously:
- state=IDLE
- redirect_valid_o=0, redirect_target_o=0, flush_ID_o=0, stall_EX_o=0
- misaligned_exc_o=0, exc_tval_o=0, redirect_cnt_o=0, flush counter=0
REQ-037 Reset mid-REDIRECT or mid-FLUSH SHALL abandon the request with no count increment; operation resumes on the first clock edge after rst_i deasserts.

Verification
REQ-038 Taken branch, a=32'h0000_1000, b=32'h0000_0020, ready=1 on first valid cycle -> target 32'h0000_1020; valid for 1 cycle; flush_ID_o high 2 cycles; count=1.
REQ-039 JALR, a=32'h0000_2003, b=32'h0, ready held 0 for 3 cycles -> target 32'h0000_2002 held stable; valid and stall high 3 cycles then handshake; no exception.
REQ-040 SUPPORT_C=0, JAL, a=32'h100, b=32'h2 -> misaligned_exc_o pulse, exc_tval_o=32'h102, redirect_valid_o stays 0.
REQ-041 kill_i asserted in the same cycle as the handshake -> state IDLE next cycle; no flush; count unchanged.
REQ-042 Wrap and saturate:
- a=32'hFFFF_FFF0, b=32'h20 -> target 32'h0000_0010
- preload count to 16'hFFFF, complete one redirect -> count stays 16'hFFFF
REQ-043 rst_i asserted in FLUSH cycle 1 -> all outputs 0 immediately; first redirect after reset behaves per REQ-038.
